uart_rx_fifo: RTL and testbench

Serial 8N1 receiver with a small receive FIFO. It is the counterpart of the transmit path in the microcontroller top level. It samples the `rx` pin at `RATE_FREQ_BAUD` clocks per bit and assembles bytes. Received bytes are queued for the MIPS core to read through memory-mapped access decoded at the top level. Queue status drives a level interrupt toward the interrupt controller.

---
 rtl/uart_rx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a receive queue (FIFO when UART_RX_FIFO_EN, else one holding register).
// Latency: byte visible one cycle after the stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: none on the line; a byte arriving at a full queue is dropped and flagged as overrun.
module uart_rx_fifo #(
    parameter int RATE_FREQ_BAUD = 434,
    parameter int FIFO_AW        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rd,
    input  logic               clr,
    output logic [7:0]         data_out,
    output logic               data_av,
    output logic [FIFO_AW:0]   level,
    output logic               overrun,
    output logic               frame_err,
    output logic               irq
);

    localparam int BW = $clog2(RATE_FREQ_BAUD);
    localparam logic [BW-1:0] HALF_M1 = BW'(RATE_FREQ_BAUD / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(RATE_FREQ_BAUD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rx_meta, rx_s, rx_q;
    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic stop_hit, push, pop, full_eff, push_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Edge detect, so a held-low break line cannot retrigger
                    if (rx_q && !rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_M1) begin
                        if (!rx_s) begin
                            state    <= DATA;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_M1) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_M1) state <= IDLE;
                    else                     baud_cnt <= baud_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stop_hit = (state == STOP) && (baud_cnt == FULL_M1);
    assign push     = stop_hit && rx_s;

`ifdef UART_RX_FIFO_EN
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW:0] wp, rp;

    assign level    = wp - rp;
    assign pop      = rd && (level != '0);
    // A same-cycle pop frees a slot before the push is considered
    assign full_eff = (level == DEPTH) && !pop;
    assign push_ok  = push && !full_eff;
    assign data_out = mem[rp[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[FIFO_AW-1:0]] <= shreg;
    end
`else
    logic [7:0] hold;
    logic       hold_vld;

    assign level    = {{FIFO_AW{1'b0}}, hold_vld};
    assign pop      = rd && hold_vld;
    assign full_eff = hold_vld && !pop;
    assign push_ok  = push && !full_eff;
    assign data_out = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= 1'b0;
        end else if (push_ok) begin
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) hold <= shreg;
    end
`endif

    assign data_av = (level != '0);
    assign irq     = data_av;

    // Sticky flags: a new error in the clear cycle wins
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (push && full_eff) || (overrun && !clr);
            frame_err <= (stop_hit && !rx_s) || (frame_err && !clr);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: exact-cycle check at RATE=434, queue-model checks at a short bit time.
module tb_uart_rx_fifo;

    localparam int R   = 21;
    localparam int FAW = 3;
    localparam int P   = 2 + R / 2 + 9 * R;   // stop-sample edge relative to the first low edge
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 1 << FAW;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rx, rd, clr, s_rd, s_clr;
    logic [7:0]   data_out, s_data_out;
    logic [FAW:0] level, s_level;
    logic data_av, overrun, frame_err, irq;
    logic s_data_av, s_overrun, s_frame_err, s_irq;

    uart_rx_fifo #(.RATE_FREQ_BAUD(R), .FIFO_AW(FAW)) u_dut (
        .clk(clk), .rst(rst), .rx(rx), .rd(rd), .clr(clr),
        .data_out(data_out), .data_av(data_av), .level(level),
        .overrun(overrun), .frame_err(frame_err), .irq(irq)
    );

    uart_rx_fifo #(.RATE_FREQ_BAUD(434), .FIFO_AW(FAW)) u_slow (
        .clk(clk), .rst(rst), .rx(rx), .rd(s_rd), .clr(s_clr),
        .data_out(s_data_out), .data_av(s_data_av), .level(s_level),
        .overrun(s_overrun), .frame_err(s_frame_err), .irq(s_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    bit         m_ovr, m_fe;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 32'(level), q.size());
        chk({tag, ".data_av"}, 32'(data_av), 32'(q.size() != 0));
        chk({tag, ".irq"}, 32'(irq), 32'(q.size() != 0));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
        if (q.size() != 0) chk({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
    endtask

    task automatic do_reset();
        rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
        tick();
    endtask

    task automatic pop_one(input string tag);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    // Drives one frame on rx; optionally strobes rd in exactly the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, input bit rd_stop);
        logic [9:0] fr;
        fr = {stop_b, b, 1'b0};
        for (int j = 0; j < 10 * R; j++) begin
            rx = fr[j / R];
            rd = rd_stop && (j == P);
            tick();
        end
        rx = 1'b1; rd = 1'b0;
        if (rd_stop && q.size() != 0) void'(q.pop_front());
        if (!stop_b) begin
            m_fe = 1'b1;
            repeat (R) tick();
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] b;
        logic       sb;
        bit         rs;
        s_rd = 1'b0; s_clr = 1'b0;
        rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
        tick(); tick();
        check_state("reset");
        chk("reset.slow_level", 32'(s_level), 0);
        rst = 1'b0;
        tick(); tick();

        // Exact arrival cycle at the nominal bit time
        fr = {1'b1, 8'h55, 1'b0};
        for (int j = 0; j < 4340; j++) begin
            rx = fr[j / 434];
            tick();
            if (j == 4124) chk("slow.av_early", 32'(s_data_av), 0);
            if (j == 4125) begin
                chk("slow.av", 32'(s_data_av), 1);
                chk("slow.data", 32'(s_data_out), 32'h55);
                chk("slow.level", 32'(s_level), 1);
                chk("slow.irq", 32'(s_irq), 1);
                chk("slow.flags", 32'({s_overrun, s_frame_err}), 0);
            end
        end
        rx = 1'b1;
        do_reset();
        check_state("post_reset");

        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check_state("b2b");
        repeat (3) pop_one("b2b_rd");

        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
        check_state("fill9");
        while (q.size() != 0) pop_one("fill9_rd");
        do_clr();
        check_state("clr_ovr");

        send_frame(8'h3C, 1'b0, 1'b0);
        check_state("frame_err");
        rx = 1'b0;
        repeat (R / 4) tick();
        rx = 1'b1;
        repeat (2 * R) tick();
        check_state("glitch");
        do_clr();
        send_frame(8'h96, 1'b1, 1'b0);
        check_state("after_glitch");
        pop_one("after_glitch_rd");

        for (int i = 0; i < DEPTH; i++) send_frame(8'(8'hC0 + i), 1'b1, 1'b0);
        check_state("full");
        send_frame(8'hE7, 1'b1, 1'b1);
        check_state("full_rd_push");
        while (q.size() != 0) pop_one("full_drain");

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check_state("pre_rst");
        fr = {1'b1, 8'h5A, 1'b0};
        for (int j = 0; j < 4 * R; j++) begin
            rx = fr[j / R];
            tick();
        end
        rst = 1'b1; rx = 1'b1;
        tick(); tick();
        rst = 1'b0;
        q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
        repeat (R) tick();
        check_state("mid_rst");
        send_frame(8'h81, 1'b1, 1'b0);
        check_state("after_rst");
        pop_one("after_rst_rd");
        pop_one("empty_rd");

        for (int i = 0; i < 30; i++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 7) != 0);
            rs = ($urandom_range(0, 3) == 0);
            send_frame(b, sb, rs);
            check_state("rand");
            repeat ($urandom_range(0, 2)) pop_one("rand_rd");
            if ($urandom_range(0, 4) == 0) begin
                do_clr();
                check_state("rand_clr");
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        while (q.size() != 0) pop_one("final_drain");
        pop_one("final_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
